// File: rtl/time_count.sv
// BCD 24-hour time-of-day counter (hh:mm:ss) advanced by a one-second enable plus correction strobes.
// Latency: every field updates on the first CLK edge that samples its enable; outputs come straight from flops.
// Backpressure: none; strobes are level-sampled every cycle and a held strobe advances once per cycle.
module time_count (
  input  logic       CLK,
  input  logic       RESETL,
  input  logic       EN1HZ,
  input  logic       sec_resetl,
  input  logic       min_inc,
  input  logic       hour_inc,
  output logic [2:0] sec_h,
  output logic [3:0] sec_l,
  output logic [2:0] min_h,
  output logic [3:0] min_l,
  output logic [1:0] hour_h,
  output logic [3:0] hour_l
);

  logic [2:0] sec_h_q, sec_h_d;
  logic [3:0] sec_l_q, sec_l_d;
  logic [2:0] min_h_q, min_h_d;
  logic [3:0] min_l_q, min_l_d;
  logic [1:0] hour_h_q, hour_h_d;
  logic [3:0] hour_l_q, hour_l_d;

  logic sec_legal, sec_is_59, sec_carry;
  logic min_legal, min_is_59, min_step, min_carry;
  logic hour_legal, hour_is_23, hour_step;

  // Field status decode; carries ripple combinationally so 23:59:59 wraps in one edge.
  always_comb begin
    sec_legal  = (sec_l_q <= 4'd9) && (sec_h_q <= 3'd5);
    sec_is_59  = (sec_h_q == 3'd5) && (sec_l_q == 4'd9);
    sec_carry  = sec_resetl & EN1HZ & sec_is_59;

    min_legal  = (min_l_q <= 4'd9) && (min_h_q <= 3'd5);
    min_is_59  = (min_h_q == 3'd5) && (min_l_q == 4'd9);
    min_step   = sec_carry | min_inc;
    // Only a seconds rollover carries into hours; the minute correction strobe wraps silently.
    min_carry  = sec_carry & min_is_59;

    hour_legal = (hour_l_q <= 4'd9) &&
                 ((hour_h_q < 2'd2) || ((hour_h_q == 2'd2) && (hour_l_q <= 4'd3)));
    hour_is_23 = (hour_h_q == 2'd2) && (hour_l_q == 4'd3);
    hour_step  = min_carry | hour_inc;
  end

  // Seconds next state: clear has priority over the 1 Hz tick; illegal contents reload 0 on a tick.
  always_comb begin
    sec_h_d = sec_h_q;
    sec_l_d = sec_l_q;
    if (!sec_resetl) begin
      sec_h_d = 3'd0;
      sec_l_d = 4'd0;
    end else if (EN1HZ) begin
      if (!sec_legal || sec_is_59) begin
        sec_h_d = 3'd0;
        sec_l_d = 4'd0;
      end else if (sec_l_q == 4'd9) begin
        sec_h_d = sec_h_q + 3'd1;
        sec_l_d = 4'd0;
      end else begin
        sec_l_d = sec_l_q + 4'd1;
      end
    end
  end

  // Minutes next state: one +1 per cycle whether from carry, correction or both.
  always_comb begin
    min_h_d = min_h_q;
    min_l_d = min_l_q;
    if (min_step) begin
      if (!min_legal || min_is_59) begin
        min_h_d = 3'd0;
        min_l_d = 4'd0;
      end else if (min_l_q == 4'd9) begin
        min_h_d = min_h_q + 3'd1;
        min_l_d = 4'd0;
      end else begin
        min_l_d = min_l_q + 4'd1;
      end
    end
  end

  // Hours next state: 00..23 with 23 wrapping to 00; out-of-range contents reload 0.
  always_comb begin
    hour_h_d = hour_h_q;
    hour_l_d = hour_l_q;
    if (hour_step) begin
      if (!hour_legal || hour_is_23) begin
        hour_h_d = 2'd0;
        hour_l_d = 4'd0;
      end else if (hour_l_q == 4'd9) begin
        hour_h_d = hour_h_q + 2'd1;
        hour_l_d = 4'd0;
      end else begin
        hour_l_d = hour_l_q + 4'd1;
      end
    end
  end

  // Digit registers; asynchronous reset forces 00:00:00 regardless of any pending carry.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      sec_h_q  <= 3'd0;
      sec_l_q  <= 4'd0;
      min_h_q  <= 3'd0;
      min_l_q  <= 4'd0;
      hour_h_q <= 2'd0;
      hour_l_q <= 4'd0;
    end else begin
      sec_h_q  <= sec_h_d;
      sec_l_q  <= sec_l_d;
      min_h_q  <= min_h_d;
      min_l_q  <= min_l_d;
      hour_h_q <= hour_h_d;
      hour_l_q <= hour_l_d;
    end
  end

  assign sec_h  = sec_h_q;
  assign sec_l  = sec_l_q;
  assign min_h  = min_h_q;
  assign min_l  = min_l_q;
  assign hour_h = hour_h_q;
  assign hour_l = hour_l_q;

endmodule

// File: tb/tb_time_count.sv
// Directed bench for time_count: vector table of single-cycle events plus reset, held-strobe and full-day runs.
// Expected times come from hand-written values and a seconds-of-day reference counter.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_time_count;

  logic       CLK = 1'b0;
  logic       RESETL = 1'b0;
  logic       EN1HZ = 1'b0;
  logic       sec_resetl = 1'b1;
  logic       min_inc = 1'b0;
  logic       hour_inc = 1'b0;
  logic [2:0] sec_h;
  logic [3:0] sec_l;
  logic [2:0] min_h;
  logic [3:0] min_l;
  logic [1:0] hour_h;
  logic [3:0] hour_l;

  int n_tests = 0;
  int n_fail  = 0;

  time_count dut (
    .CLK        (CLK),
    .RESETL     (RESETL),
    .EN1HZ      (EN1HZ),
    .sec_resetl (sec_resetl),
    .min_inc    (min_inc),
    .hour_inc   (hour_inc),
    .sec_h      (sec_h),
    .sec_l      (sec_l),
    .min_h      (min_h),
    .min_l      (min_l),
    .hour_h     (hour_h),
    .hour_l     (hour_l)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    int    sh, sm, ss;
    logic  en, sres, minc, hinc;
    int    eh, em, es;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [19:0] exp_vec(input int h, input int m, input int s);
    logic [1:0] hh;
    logic [3:0] hl, ml, sl;
    logic [2:0] mh, sh;
    hh = 2'(h / 10);
    hl = 4'(h % 10);
    mh = 3'(m / 10);
    ml = 4'(m % 10);
    sh = 3'(s / 10);
    sl = 4'(s % 10);
    return {hh, hl, mh, ml, sh, sl};
  endfunction

  function automatic string vec_str(input logic [19:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", v[19:18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0]);
  endfunction

  task automatic check(input string name, input int h, input int m, input int s);
    logic [19:0] got, want;
    got  = {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
    want = exp_vec(h, m, s);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %s required %s", name, vec_str(got), vec_str(want));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges, then load h:m:s through held strobes.
  task automatic set_time(input int h, input int m, input int s);
    EN1HZ = 1'b0; min_inc = 1'b0; hour_inc = 1'b0; sec_resetl = 1'b1;
    RESETL = 1'b0;
    #2;
    RESETL = 1'b1;
    tick();
    hour_inc = 1'b1;
    repeat (h) tick();
    hour_inc = 1'b0;
    min_inc = 1'b1;
    repeat (m) tick();
    min_inc = 1'b0;
    EN1HZ = 1'b1;
    repeat (s) tick();
    EN1HZ = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"sclr_prio",      12, 34, 59, 1'b1, 1'b0, 1'b0, 1'b0, 12, 34,  0};
    vecs[1]  = '{"min_inc_wrap",    5, 59, 30, 1'b0, 1'b1, 1'b1, 1'b0,  5,  0, 30};
    vecs[2]  = '{"min_inc_carry",   5, 58, 59, 1'b1, 1'b1, 1'b1, 1'b0,  5, 59,  0};
    vecs[3]  = '{"hour_inc_22",    22, 10, 10, 1'b0, 1'b1, 1'b0, 1'b1, 23, 10, 10};
    vecs[4]  = '{"hour_inc_23",    23, 10, 10, 1'b0, 1'b1, 1'b0, 1'b1,  0, 10, 10};
    vecs[5]  = '{"hour_inc_00",     0, 10, 10, 1'b0, 1'b1, 1'b0, 1'b1,  1, 10, 10};
    vecs[6]  = '{"hour_inc_mcarry", 7, 59, 59, 1'b1, 1'b1, 1'b0, 1'b1,  8,  0,  0};
    vecs[7]  = '{"day_wrap",       23, 59, 59, 1'b1, 1'b1, 1'b0, 1'b0,  0,  0,  0};
    vecs[8]  = '{"ripple_09_10",    9, 59, 59, 1'b1, 1'b1, 1'b0, 1'b0, 10,  0,  0};
    vecs[9]  = '{"ripple_00_01",    0, 59, 59, 1'b1, 1'b1, 1'b0, 1'b0,  1,  0,  0};
    vecs[10] = '{"sclr_only",      12, 34, 56, 1'b0, 1'b0, 1'b0, 1'b0, 12, 34,  0};
    vecs[11] = '{"hour_19_20",     19, 59,  0, 1'b0, 1'b1, 1'b0, 1'b1, 20, 59,  0};
    vecs[12] = '{"sec_units",       3,  7,  9, 1'b1, 1'b1, 1'b0, 1'b0,  3,  7, 10};
    vecs[13] = '{"idle_hold",       4, 25, 37, 1'b0, 1'b1, 1'b0, 1'b0,  4, 25, 37};
    vecs[14] = '{"min_inc_no_hcarry",12, 59, 59, 1'b0, 1'b1, 1'b1, 1'b0, 12,  0, 59};
    vecs[15] = '{"sec_carry_minc", 12, 34, 59, 1'b1, 1'b1, 1'b1, 1'b0, 12, 35,  0};
    vecs[16] = '{"ripple_min",      0,  0, 59, 1'b1, 1'b1, 1'b0, 1'b0,  0,  1,  0};

    // Reset state
    #1;
    check("reset_state", 0, 0, 0);
    RESETL = 1'b1;
    tick();
    check("post_release_idle", 0, 0, 0);

    // Table vectors: preset, verify preset, apply one cycle, verify result
    for (int i = 0; i < 17; i++) begin
      set_time(vecs[i].sh, vecs[i].sm, vecs[i].ss);
      check({vecs[i].name, "_preset"}, vecs[i].sh, vecs[i].sm, vecs[i].ss);
      EN1HZ = vecs[i].en; sec_resetl = vecs[i].sres;
      min_inc = vecs[i].minc; hour_inc = vecs[i].hinc;
      tick();
      EN1HZ = 1'b0; sec_resetl = 1'b1; min_inc = 1'b0; hour_inc = 1'b0;
      check(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es);
    end

    // Three back-to-back one-cycle hour pulses from 22:10:10
    set_time(22, 10, 10);
    hour_inc = 1'b1; tick(); hour_inc = 1'b0; check("hpulse_1", 23, 10, 10);
    hour_inc = 1'b1; tick(); hour_inc = 1'b0; check("hpulse_2",  0, 10, 10);
    hour_inc = 1'b1; tick(); hour_inc = 1'b0; check("hpulse_3",  1, 10, 10);

    // Async reset between edges, strobes ignored while held in reset
    set_time(17, 45, 12);
    check("async_preset", 17, 45, 12);
    RESETL = 1'b0;
    #2;
    check("async_clear", 0, 0, 0);
    EN1HZ = 1'b1; min_inc = 1'b1; hour_inc = 1'b1;
    tick();
    tick();
    EN1HZ = 1'b0; min_inc = 1'b0; hour_inc = 1'b0;
    check("strobes_in_reset", 0, 0, 0);
    RESETL = 1'b1;
    tick();
    check("release_idle", 0, 0, 0);
    EN1HZ = 1'b1; tick(); EN1HZ = 1'b0;
    check("first_tick", 0, 0, 1);

    // Held minute strobe: 61 cycles from midnight
    set_time(0, 0, 0);
    min_inc = 1'b1;
    repeat (61) tick();
    min_inc = 1'b0;
    check("min_held_61", 0, 1, 0);

    // Full day at one tick per cycle, compared against a seconds-of-day reference
    set_time(0, 0, 0);
    begin
      int tod;
      tod = 0;
      EN1HZ = 1'b1;
      for (int i = 0; i < 86400; i++) begin
        tick();
        tod = (tod + 1) % 86400;
        check("full_day", tod / 3600, (tod / 60) % 60, tod % 60);
      end
      EN1HZ = 1'b0;
    end
    tick();
    check("full_day_end", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
